ws2812_chain: RTL and testbench

Parametrised addressable-LED chain driver for WS2812/SK6812-class parts. It holds a frame buffer of `NUM_LEDS` pixels of 24 (RGB) or 32 (RGBW) bits and serialises them on one data line. The block sits between the host register interface and the LED output pin. It supports two modes: free-running refresh, or one frame per `start` request with a `busy`/`done` handshake. It also applies a per-frame global brightness scale.

---
 rtl/ws2812_pkg.sv | 23 ++
 rtl/ws2812_chain_bit_cell.sv | 40 ++++
 rtl/ws2812_chain.sv | 168 ++++++++++++++++
 tb/tb_ws2812_chain.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared types and elaboration-time helpers for the WS2812/SK6812 chain driver.
package ws2812_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DATA  = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    // Nanoseconds to clock cycles, rounded up so no pulse is ever short.
    function automatic int ns_to_cycles(input int clk_mhz, input int ns);
        return (clk_mhz * ns + 999) / 1000;
    endfunction

    // brightness=255 multiplies by 256, so the >>8 returns the byte unchanged.
    function automatic logic [7:0] scale_byte(input logic [7:0] b, input logic [7:0] br);
        logic [15:0] prod;
        prod = {8'd0, b} * ({8'd0, br} + 16'd1);
        return prod[15:8];
    endfunction

endpackage

// File: rtl/ws2812_chain_bit_cell.sv
// One WS2812 bit cell: TP cycles, high for T1 (one) or T0 (zero) cycles from the start.
module ws2812_bit_cell #(
    parameter int T1 = 11,
    parameter int T0 = 5,
    parameter int TP = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic go,
    input  logic bit_val,
    output logic high,
    output logic cell_first,
    output logic cell_end
);
    localparam int CW = (TP > 1) ? $clog2(TP) : 1;

    if (!(T0 < T1 && T1 < TP)) begin : g_bad_timing
        $error("ws2812_bit_cell: need T0 < T1 < TP");
    end

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] high_len;

    assign high_len   = bit_val ? CW'(T1) : CW'(T0);
    assign high       = go && (cnt_reg < high_len);
    assign cell_first = go && (cnt_reg == '0);
    assign cell_end   = go && (cnt_reg == CW'(TP - 1));

    // Counter parks at zero whenever the cell is not running.
    always_ff @(posedge clk) begin
        if (reset || !go) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CW'(TP - 1)) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/ws2812_chain.sv
// Addressable LED chain driver: pixel buffer, brightness scaling, prefetch and serial FSM.
module ws2812_chain
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS     = 8,
    parameter int BITS_PER_LED = 24,
    parameter int CLK_MHZ      = 12,
    parameter int T1H_NS       = 900,
    parameter int T0H_NS       = 350,
    parameter int TBIT_NS      = 1250,
    parameter int TRESET_US    = 280,
    parameter bit CONTINUOUS   = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [BITS_PER_LED-1:0] rgb_data,
    input  logic [7:0]              led_num,
    input  logic                    write,
    input  logic [7:0]              brightness,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    data
);
    localparam int T1 = ns_to_cycles(CLK_MHZ, T1H_NS);
    localparam int T0 = ns_to_cycles(CLK_MHZ, T0H_NS);
    localparam int TP = ns_to_cycles(CLK_MHZ, TBIT_NS);
    localparam int TR = CLK_MHZ * TRESET_US;
    localparam int RW = $clog2(TR + 1);
    localparam int LW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int BW = $clog2(BITS_PER_LED);
    localparam int NB = BITS_PER_LED / 8;

    if (!(BITS_PER_LED == 24 || BITS_PER_LED == 32)) begin : g_bad_bpl
        $error("ws2812_chain: BITS_PER_LED must be 24 or 32");
    end
    if (NUM_LEDS < 1 || NUM_LEDS > 256) begin : g_bad_leds
        $error("ws2812_chain: NUM_LEDS must be 1..256");
    end
    if (!(T0 < T1 && T1 < TP)) begin : g_bad_timing
        $error("ws2812_chain: need T0 < T1 < TP");
    end

    logic [BITS_PER_LED-1:0] mem [NUM_LEDS];
    logic [BITS_PER_LED-1:0] rd_q_reg, prefetch_reg, shift_reg, scaled;
    state_t                  state_reg;
    logic [RW-1:0]           latch_cnt_reg;
    logic [LW-1:0]           led_idx_reg, rd_addr;
    logic [BW-1:0]           bit_cnt_reg;
    logic [7:0]              bright_reg;
    logic                    load_phase_reg, scale_pend_reg, data_reg;
    logic                    rd_en, cell_high, cell_first, cell_end, last_bit, last_led;

    assign last_bit = (bit_cnt_reg == BW'(BITS_PER_LED - 1));
    assign last_led = (led_idx_reg == LW'(NUM_LEDS - 1));
    assign busy     = (state_reg != ST_IDLE);
    assign done     = (state_reg == ST_LATCH) && (latch_cnt_reg == '0);
    assign data     = data_reg;

    // Fetch the next pixel at the start of the current pixel's last bit, as late as
    // possible so host writes made during the current pixel still make this frame.
    always_comb begin
        rd_en   = 1'b0;
        rd_addr = '0;
        if (state_reg == ST_LOAD && !load_phase_reg) begin
            rd_en = 1'b1;
        end else if (state_reg == ST_DATA && cell_first && last_bit && !last_led) begin
            rd_en   = 1'b1;
            rd_addr = led_idx_reg + LW'(1);
        end
    end

    for (genvar gi = 0; gi < NB; gi++) begin : g_scale
        assign scaled[gi*8 +: 8] = scale_byte(rd_q_reg[gi*8 +: 8], bright_reg);
    end

    // Read-first buffer: a write on the fetch edge is not seen by that fetch.
    always_ff @(posedge clk) begin
        if (write && ({1'b0, led_num} < 9'(NUM_LEDS))) begin
            mem[LW'(led_num)] <= rgb_data;
        end
        if (rd_en) begin
            rd_q_reg <= mem[rd_addr];
        end
    end

    ws2812_bit_cell #(
        .T1(T1),
        .T0(T0),
        .TP(TP)
    ) u_bit_cell (
        .clk       (clk),
        .reset     (reset),
        .go        (state_reg == ST_DATA),
        .bit_val   (shift_reg[BITS_PER_LED-1]),
        .high      (cell_high),
        .cell_first(cell_first),
        .cell_end  (cell_end)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= CONTINUOUS ? ST_LATCH : ST_IDLE;
            latch_cnt_reg  <= RW'(TR - 1);
            led_idx_reg    <= '0;
            bit_cnt_reg    <= '0;
            bright_reg     <= '0;
            load_phase_reg <= 1'b0;
            scale_pend_reg <= 1'b0;
            shift_reg      <= '0;
            prefetch_reg   <= '0;
            data_reg       <= 1'b0;
        end else begin
            data_reg       <= cell_high;
            scale_pend_reg <= rd_en && (state_reg == ST_DATA);
            if (scale_pend_reg) begin
                prefetch_reg <= scaled;
            end
            unique case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg      <= ST_LOAD;
                        load_phase_reg <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (!load_phase_reg) begin
                        bright_reg     <= brightness;
                        load_phase_reg <= 1'b1;
                    end else begin
                        shift_reg      <= scaled;
                        led_idx_reg    <= '0;
                        bit_cnt_reg    <= '0;
                        load_phase_reg <= 1'b0;
                        state_reg      <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (cell_end) begin
                        if (last_bit) begin
                            bit_cnt_reg <= '0;
                            if (last_led) begin
                                state_reg     <= ST_LATCH;
                                latch_cnt_reg <= RW'(TR - 1);
                            end else begin
                                led_idx_reg <= led_idx_reg + LW'(1);
                                shift_reg   <= prefetch_reg;
                            end
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + BW'(1);
                            shift_reg   <= {shift_reg[BITS_PER_LED-2:0], 1'b0};
                        end
                    end
                end
                ST_LATCH: begin
                    if (latch_cnt_reg == '0) begin
                        state_reg      <= CONTINUOUS ? ST_LOAD : ST_IDLE;
                        load_phase_reg <= 1'b0;
                        latch_cnt_reg  <= RW'(TR - 1);
                    end else begin
                        latch_cnt_reg <= latch_cnt_reg - RW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_chain.sv
// Randomised bench: decodes the serial line into cells and pixels and compares with a pixel-level model.
module tb_ws2812_chain;
    localparam int CLK_MHZ = 12;
    localparam int T1 = (CLK_MHZ * 900 + 999) / 1000;
    localparam int T0 = (CLK_MHZ * 350 + 999) / 1000;
    localparam int TP = (CLK_MHZ * 1250 + 999) / 1000;
    localparam int TR = CLK_MHZ * 280;
    localparam int N0 = 2, B0 = 24, N1 = 2, B1 = 32;
    localparam int FRAME0 = 2 + N0 * B0 * TP + TR;
    localparam int FRAME1 = 2 + N1 * B1 * TP + TR;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, wr0, start0, busy0, done0, data0;
    logic [23:0] rgb0;
    logic [7:0]  num0, br0;
    logic        rst1, wr1, start1, busy1, done1, data1;
    logic [31:0] rgb1;
    logic [7:0]  num1, br1;

    ws2812_chain #(
        .NUM_LEDS(N0), .BITS_PER_LED(B0), .CLK_MHZ(CLK_MHZ), .T1H_NS(900), .T0H_NS(350),
        .TBIT_NS(1250), .TRESET_US(280), .CONTINUOUS(1'b0)
    ) dut0 (
        .clk(clk), .reset(rst0), .rgb_data(rgb0), .led_num(num0), .write(wr0),
        .brightness(br0), .start(start0), .busy(busy0), .done(done0), .data(data0)
    );

    ws2812_chain #(
        .NUM_LEDS(N1), .BITS_PER_LED(B1), .CLK_MHZ(CLK_MHZ), .T1H_NS(900), .T0H_NS(350),
        .TBIT_NS(1250), .TRESET_US(280), .CONTINUOUS(1'b1)
    ) dut1 (
        .clk(clk), .reset(rst1), .rgb_data(rgb1), .led_num(num1), .write(wr1),
        .brightness(br1), .start(start1), .busy(busy1), .done(done1), .data(data1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model0 [N0];
    logic [31:0] model1 [N1];

    int rise_q[$];
    int high_q[$];
    int done_q[$];
    int busy_fall, busy_first, data_first;

    // One-shot actions injected into a capture window (-1 = none)
    int          mw_k = -1, ms_k = -1, mb_k = -1;
    logic [7:0]  mw_addr;
    logic [23:0] mw_data;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [31:0] scale_pix(input logic [31:0] pix, input int br, input int bits);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < bits / 8; i++) begin
            int b;
            b = int'((pix >> (8 * i)) & 32'hFF);
            r = r | (32'((b * (br + 1)) / 256) << (8 * i));
        end
        return r;
    endfunction

    task automatic write0(input int addr, input logic [31:0] val);
        @(negedge clk);
        wr0 = 1'b1; num0 = addr[7:0]; rgb0 = val[23:0];
        if (addr < N0) model0[addr] = {8'd0, val[23:0]};
        @(negedge clk);
        wr0 = 1'b0;
    endtask

    task automatic write1(input int addr, input logic [31:0] val);
        @(negedge clk);
        wr1 = 1'b1; num1 = addr[7:0]; rgb1 = val;
        if (addr < N1) model1[addr] = val;
        @(negedge clk);
        wr1 = 1'b0;
    endtask

    // Sample one DUT for ncyc cycles; sample k holds the values after the k-th edge.
    task automatic capture(input int which, input int ncyc);
        logic d, bz, dn, prev;
        int   hstart;
        prev = 1'b0; hstart = 0;
        rise_q.delete(); high_q.delete(); done_q.delete();
        busy_fall = -1; busy_first = -1; data_first = -1;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            d  = (which == 0) ? data0 : data1;
            bz = (which == 0) ? busy0 : busy1;
            dn = (which == 0) ? done0 : done1;
            if (k == 0) begin
                busy_first = int'(bz);
                data_first = int'(d);
            end
            if (d && !prev) begin
                rise_q.push_back(k);
                hstart = k;
            end
            if (!d && prev) high_q.push_back(k - hstart);
            if (dn) done_q.push_back(k);
            if (!bz && busy_fall < 0) busy_fall = k;
            prev = d;
            wr0 = 1'b0; wr1 = 1'b0; start0 = 1'b0; start1 = 1'b0; rst0 = 1'b0; rst1 = 1'b0;
            if (which == 0) begin
                if (k == mw_k) begin
                    wr0 = 1'b1; num0 = mw_addr; rgb0 = mw_data;
                    if (int'(mw_addr) < N0) model0[mw_addr] = {8'd0, mw_data};
                end
                if (k == ms_k) start0 = 1'b1;
                if (k == mb_k) br0 = 8'($urandom);
            end else if (k == ms_k) begin
                start1 = 1'b1;
            end
        end
    endtask

    task automatic check_frame(input string tag, input int which, input int nleds, input int bits,
                               input int nframes, input int period, input int rise0,
                               input int done0_k, input int ndone, input int br, input int bfall);
        int cpf, bad_rise, bad_high, nrise;
        cpf = nleds * bits;
        bad_rise = 0; bad_high = 0;
        nrise = rise_q.size();
        check_eq({tag, " data at k0"}, data_first, 0);
        check_eq({tag, " busy at k0"}, busy_first, 1);
        check_eq({tag, " cell count"}, nrise, cpf * nframes);
        check_eq({tag, " busy fall"}, busy_fall, bfall);
        for (int c = 0; c < nrise && c < cpf * nframes; c++) begin
            if (rise_q[c] != rise0 + (c / cpf) * period + (c % cpf) * TP) bad_rise++;
        end
        check_eq({tag, " cells off-grid"}, bad_rise, 0);
        check_eq({tag, " done count"}, done_q.size(), ndone);
        for (int i = 0; i < done_q.size() && i < ndone; i++) begin
            check_eq($sformatf("%s done%0d time", tag, i), done_q[i], done0_k + i * period);
        end
        for (int f = 0; f < nframes; f++) begin
            for (int p = 0; p < nleds; p++) begin
                logic [31:0] got, exp;
                got = '0;
                for (int j = 0; j < bits; j++) begin
                    int c, h;
                    c = f * cpf + p * bits + j;
                    h = (c < high_q.size()) ? high_q[c] : -1;
                    if (h != T1 && h != T0) bad_high++;
                    got = (got << 1) | ((h == T1) ? 32'd1 : 32'd0);
                end
                exp = scale_pix((which == 0) ? model0[p] : model1[p], br, bits);
                check_eq($sformatf("%s f%0d px%0d", tag, f, p), got, exp);
            end
        end
        check_eq({tag, " bad high widths"}, bad_high, 0);
        $display("frame %s: %0d cells, %0d done pulses, brightness %0d", tag, nrise, done_q.size(), br);
    endtask

    task automatic frame0(input string tag, input int br);
        @(negedge clk);
        br0 = br[7:0]; start0 = 1'b1;
        capture(0, FRAME0 + 3);
        check_frame(tag, 0, N0, B0, 1, FRAME0, 3, FRAME0 - 1, 1, br, FRAME0);
        mw_k = -1; ms_k = -1; mb_k = -1;
    endtask

    initial begin
        rst0 = 1'b1; wr0 = 1'b0; start0 = 1'b0; rgb0 = '0; num0 = '0; br0 = 8'd255;
        rst1 = 1'b1; wr1 = 1'b0; start1 = 1'b0; rgb1 = '0; num1 = '0; br1 = 8'($urandom_range(1, 254));
        repeat (3) @(negedge clk);
        check_eq("rst data0", data0, 0);
        check_eq("rst busy0", busy0, 0);
        check_eq("rst done0", done0, 0);
        check_eq("rst data1", data1, 0);
        check_eq("rst busy1", busy1, 1);
        check_eq("rst done1", done1, 0);
        rst0 = 1'b0;

        // Directed frames from the test plan
        write0(0, 32'hFF0000);
        write0(1, 32'h000001);
        frame0("basic", 255);
        write0(0, 32'h80FF01);
        frame0("bright127", 127);
        frame0("bright0", 0);

        // Randomised frames with mid-frame writes, ignored start and brightness changes
        for (int it = 0; it < 4; it++) begin
            write0(0, $urandom);
            write0(1, $urandom);
            mw_k    = $urandom_range(10, 300);
            mw_addr = (it % 2 == 1) ? 8'(N0) : 8'd1;
            mw_data = 24'($urandom);
            ms_k    = $urandom_range(5, FRAME0 - 10);
            mb_k    = $urandom_range(5, FRAME0 - 10);
            frame0($sformatf("rand%0d", it), $urandom_range(0, 255));
        end

        // Reset in the middle of DATA, then resend the retained buffer
        @(negedge clk);
        br0 = 8'd255; start0 = 1'b1;
        capture(0, 200);
        check_eq("mid0 data high before reset", data0, 1);
        @(negedge clk);
        rst0 = 1'b1;
        @(negedge clk);
        check_eq("mid0 data after reset", data0, 0);
        check_eq("mid0 busy after reset", busy0, 0);
        check_eq("mid0 done after reset", done0, 0);
        rst0 = 1'b0;
        frame0("after reset", 255);

        // Continuous mode, 32-bit pixels
        @(negedge clk);
        rst1 = 1'b0;
        write1(0, $urandom);
        write1(1, $urandom);
        @(negedge clk);
        rst1 = 1'b1;
        ms_k = 50;
        capture(1, TR + 2 * FRAME1 + 2);
        check_frame("cont", 1, N1, B1, 2, FRAME1, TR + 3, TR - 1, 3, int'(br1), -1);
        ms_k = -1;
        capture(1, 304);
        check_eq("mid1 data high before reset", data1, 1);
        @(negedge clk);
        rst1 = 1'b1;
        capture(1, TR + FRAME1 + 2);
        check_frame("cont rst", 1, N1, B1, 1, FRAME1, TR + 3, TR - 1, 2, int'(br1), -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
